dsp_ctrl: RTL and testbench

//  Command sequencer for the character display (dsp) bus. Accepts a stream of

---
 rtl/dsp_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_dsp_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_ctrl.sv
// Character display command sequencer: cursor tracking, put/newline/clear,
// and autonomous one-line scroll over the dsp word bus.
module dsp_ctrl #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 30,
  parameter logic [15:0] BLANK = 16'h0720
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        dsp_en,
  output logic        dsp_wr,
  output logic [11:0] dsp_addr,
  output logic [15:0] dsp_wdata,
  input  logic [15:0] dsp_rdata,
  input  logic        dsp_wt,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  typedef enum logic [2:0] {
    IDLE, PUT, NL, SCR_RD, SCR_WR, FILL, CLR
  } state_t;

  state_t state, state_n;

  logic        en_n, wr_n;
  logic [11:0] addr_n;
  logic [15:0] wdata_n;
  logic [4:0]  row_n, prow, prow_n;
  logic [6:0]  col_n, pcol, pcol_n;

  logic        done;
  logic        is_putc, is_nl, is_clr, is_set;
  logic [4:0]  set_row;
  logic [6:0]  set_col;
  logic        p_end_col, p_end;
  logic [4:0]  p_nrow;
  logic [6:0]  p_ncol;

  assign done      = dsp_en & ~dsp_wt;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  assign is_putc = (cmd_op == 2'b00);
  assign is_nl   = (cmd_op == 2'b01);
  assign is_clr  = (cmd_op == 2'b10);
  assign is_set  = (cmd_op == 2'b11);

  assign set_row = (cmd_data[12:8] > LAST_ROW)
                 ? LAST_ROW : cmd_data[12:8];
  assign set_col = (cmd_data[6:0] > LAST_COL)
                 ? LAST_COL : cmd_data[6:0];

  // Row-major walk shared by scroll source and clear
  assign p_end_col = (pcol == LAST_COL);
  assign p_end     = p_end_col && (prow == LAST_ROW);
  assign p_nrow    = p_end_col ? prow + 5'd1 : prow;
  assign p_ncol    = p_end_col ? 7'd0 : pcol + 7'd1;

  always_comb begin
    state_n = state;
    en_n    = dsp_en;
    wr_n    = dsp_wr;
    addr_n  = dsp_addr;
    wdata_n = dsp_wdata;
    row_n   = cur_row;
    col_n   = cur_col;
    prow_n  = prow;
    pcol_n  = pcol;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          unique case (1'b1)
            is_putc: begin
              state_n = PUT;
              en_n    = 1'b1;
              wr_n    = 1'b1;
              addr_n  = {cur_row, cur_col};
              wdata_n = cmd_data;
            end
            is_nl: state_n = NL;
            is_clr: begin
              state_n = CLR;
              en_n    = 1'b1;
              wr_n    = 1'b1;
              addr_n  = 12'd0;
              wdata_n = BLANK;
              prow_n  = 5'd0;
              pcol_n  = 7'd0;
            end
            is_set: begin
              row_n = set_row;
              col_n = set_col;
            end
            default: state_n = IDLE;
          endcase
        end
      end
      PUT: begin
        if (done) begin
          en_n = 1'b0;
          if (cur_col == LAST_COL) begin
            col_n   = 7'd0;
            state_n = NL;
          end else begin
            col_n   = cur_col + 7'd1;
            state_n = IDLE;
          end
        end
      end
      NL: begin
        col_n = 7'd0;
        if (cur_row < LAST_ROW) begin
          row_n   = cur_row + 5'd1;
          state_n = IDLE;
        end else begin
          state_n = SCR_RD;
          en_n    = 1'b1;
          wr_n    = 1'b0;
          addr_n  = {5'd1, 7'd0};
          prow_n  = 5'd1;
          pcol_n  = 7'd0;
        end
      end
      SCR_RD: begin
        if (done) begin
          state_n = SCR_WR;
          wr_n    = 1'b1;
          addr_n  = {prow - 5'd1, pcol};
          wdata_n = dsp_rdata;
        end
      end
      SCR_WR: begin
        if (done) begin
          if (p_end) begin
            state_n = FILL;
            addr_n  = {LAST_ROW, 7'd0};
            wdata_n = BLANK;
            pcol_n  = 7'd0;
          end else begin
            state_n = SCR_RD;
            wr_n    = 1'b0;
            addr_n  = {p_nrow, p_ncol};
            prow_n  = p_nrow;
            pcol_n  = p_ncol;
          end
        end
      end
      FILL: begin
        if (done) begin
          if (p_end_col) begin
            state_n = IDLE;
            en_n    = 1'b0;
          end else begin
            pcol_n = pcol + 7'd1;
            addr_n = {prow, pcol + 7'd1};
          end
        end
      end
      CLR: begin
        if (done) begin
          if (p_end) begin
            state_n = IDLE;
            en_n    = 1'b0;
            row_n   = 5'd0;
            col_n   = 7'd0;
          end else begin
            prow_n = p_nrow;
            pcol_n = p_ncol;
            addr_n = {p_nrow, p_ncol};
          end
        end
      end
      default: begin
        state_n = IDLE;
        en_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dsp_en    <= 1'b0;
      dsp_wr    <= 1'b0;
      dsp_addr  <= 12'd0;
      dsp_wdata <= 16'd0;
      cur_row   <= 5'd0;
      cur_col   <= 7'd0;
      prow      <= 5'd0;
      pcol      <= 7'd0;
    end else begin
      state     <= state_n;
      dsp_en    <= en_n;
      dsp_wr    <= wr_n;
      dsp_addr  <= addr_n;
      dsp_wdata <= wdata_n;
      cur_row   <= row_n;
      cur_col   <= col_n;
      prow      <= prow_n;
      pcol      <= pcol_n;
    end
  end

endmodule

// File: tb/tb_dsp_ctrl.sv
// Directed bench for dsp_ctrl: command table, clear, scroll,
// wait-stall stability and mid-scroll reset against a dsp memory model.
module tb_dsp_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_data = 16'h0;
  logic        cmd_ready, dsp_en, dsp_wr, busy;
  logic [11:0] dsp_addr;
  logic [15:0] dsp_wdata, dsp_rdata;
  logic        dsp_wt = 1'b0;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;

  dsp_ctrl dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .dsp_en(dsp_en), .dsp_wr(dsp_wr),
    .dsp_addr(dsp_addr), .dsp_wdata(dsp_wdata),
    .dsp_rdata(dsp_rdata), .dsp_wt(dsp_wt),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] BLANK = 16'h0720;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [4096];
  int          n_wr = 0, n_rd = 0, n_bad = 0;
  logic [11:0] last_addr = 12'h0;
  logic [15:0] last_data = 16'h0;
  logic        do_preload = 1'b0;
  bit          stall_en = 1'b0;
  int          stall_left = 0;
  int          stall_chk = 0, stall_bad = 0;
  logic        snap_v = 1'b0;
  logic [29:0] snap = 30'h0;
  int          rdy_bad = 0, busy_cyc = 0;

  assign dsp_rdata = mem[dsp_addr];

  function automatic logic [15:0] pat(int r, int c);
    return 16'(r * 256 + c + 1);
  endfunction

  // dsp memory model
  always @(posedge clk) begin
    if (do_preload) begin
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 128; c++)
          mem[{5'(r), 7'(c)}] <= (r < 30 && c < 80)
                               ? pat(r, c) : 16'hDEAD;
    end else if (!reset && dsp_en && !dsp_wt) begin
      if (dsp_addr[6:0] >= 7'd80 || dsp_addr[11:7] >= 5'd30)
        n_bad++;
      if (dsp_wr) begin
        mem[dsp_addr] <= dsp_wdata;
        n_wr++;
        last_addr = dsp_addr;
        last_data = dsp_wdata;
      end else begin
        n_rd++;
      end
    end
  end

  // wait driver plus hold-stable observer
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_ready === busy) rdy_bad++;
      if (busy) busy_cyc++;
      if (snap_v) begin
        stall_chk++;
        if ({dsp_en, dsp_wr, dsp_addr, dsp_wdata} !== snap)
          stall_bad++;
      end
    end
    if (!stall_en) begin
      dsp_wt = 1'b0;
    end else if (stall_left > 0) begin
      dsp_wt = 1'b1;
      stall_left--;
    end else if ($urandom_range(0, 2) == 0) begin
      dsp_wt = 1'b1;
      stall_left = $urandom_range(0, 4);
    end else begin
      dsp_wt = 1'b0;
    end
    snap   = {dsp_en, dsp_wr, dsp_addr, dsp_wdata};
    snap_v = !reset && dsp_en && dsp_wt;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] d);
    int k = 0;
    while (!cmd_ready && k < 60000) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk("issue_ready", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60000) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  task automatic preload();
    do_preload = 1'b1;
    @(negedge clk);
    do_preload = 1'b0;
  endtask

  function automatic int scroll_errs();
    int e = 0;
    logic [15:0] x;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 128; c++) begin
        if (r < 29 && c < 80) x = pat(r + 1, c);
        else if (r == 29 && c < 80) x = BLANK;
        else x = 16'hDEAD;
        if (mem[{5'(r), 7'(c)}] !== x) e++;
      end
    return e;
  endfunction

  function automatic int clear_errs();
    int e = 0;
    logic [15:0] x;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 128; c++) begin
        x = (r < 30 && c < 80) ? BLANK : 16'hDEAD;
        if (mem[{5'(r), 7'(c)}] !== x) e++;
      end
    return e;
  endfunction

  task automatic do_scroll(input string tag);
    int w0, r0;
    preload();
    issue(2'b11, {3'b0, 5'd29, 1'b0, 7'd0});
    w0 = n_wr;
    r0 = n_rd;
    issue(2'b01, 16'h0);
    wait_idle();
    chk({tag, "_writes"}, 32'(n_wr - w0), 32'd2400);
    chk({tag, "_reads"}, 32'(n_rd - r0), 32'd2320);
    chk({tag, "_image"}, 32'(scroll_errs()), 32'd0);
    chk({tag, "_row"}, 32'(cur_row), 32'd29);
    chk({tag, "_col"}, 32'(cur_col), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [4:0]  row;
    logic [6:0]  col;
    int          wr;
    logic [11:0] addr;
    logic [15:0] wd;
  } vec_t;

  vec_t vt[9];

  initial begin
    int w0, r0, c0;
    vt[0] = '{2'b00, 16'h0741, 5'd0,  7'd1,  1, 12'h000, 16'h0741};
    vt[1] = '{2'b11, 16'h054F, 5'd5,  7'd79, 0, 12'h000, 16'h0000};
    vt[2] = '{2'b00, 16'h0742, 5'd6,  7'd0,  1, 12'h2CF, 16'h0742};
    vt[3] = '{2'b11, 16'h1F7F, 5'd29, 7'd79, 0, 12'h000, 16'h0000};
    vt[4] = '{2'b11, 16'h1D50, 5'd29, 7'd79, 0, 12'h000, 16'h0000};
    vt[5] = '{2'b11, 16'h030A, 5'd3,  7'd10, 0, 12'h000, 16'h0000};
    vt[6] = '{2'b01, 16'h0000, 5'd4,  7'd0,  0, 12'h000, 16'h0000};
    vt[7] = '{2'b00, 16'h1234, 5'd4,  7'd1,  1, 12'h200, 16'h1234};
    vt[8] = '{2'b11, 16'hE080, 5'd0,  7'd0,  0, 12'h000, 16'h0000};

    preload();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_en",    {31'b0, dsp_en}, 32'd0);
    chk("rst_wr",    {31'b0, dsp_wr}, 32'd0);
    chk("rst_addr",  32'(dsp_addr), 32'd0);
    chk("rst_wdata", 32'(dsp_wdata), 32'd0);
    chk("rst_cursor", 32'({cur_row, cur_col}), 32'd0);

    foreach (vt[i]) begin
      w0 = n_wr;
      r0 = n_rd;
      issue(vt[i].op, vt[i].data);
      wait_idle();
      chk($sformatf("v%0d_row", i), 32'(cur_row), 32'(vt[i].row));
      chk($sformatf("v%0d_col", i), 32'(cur_col), 32'(vt[i].col));
      chk($sformatf("v%0d_writes", i), 32'(n_wr - w0), 32'(vt[i].wr));
      chk($sformatf("v%0d_reads", i), 32'(n_rd - r0), 32'd0);
      if (vt[i].wr > 0) begin
        chk($sformatf("v%0d_addr", i), 32'(last_addr), 32'(vt[i].addr));
        chk($sformatf("v%0d_data", i), 32'(last_data), 32'(vt[i].wd));
      end
    end

    // full clear, no stalls
    preload();
    issue(2'b11, 16'h0A05);
    w0 = n_wr;
    r0 = n_rd;
    c0 = busy_cyc;
    issue(2'b10, 16'h0);
    wait_idle();
    chk("clr_writes", 32'(n_wr - w0), 32'd2400);
    chk("clr_reads", 32'(n_rd - r0), 32'd0);
    chk("clr_cycles", 32'(busy_cyc - c0), 32'd2400);
    chk("clr_last_addr", 32'(last_addr), 32'({5'd29, 7'd79}));
    chk("clr_image", 32'(clear_errs()), 32'd0);
    chk("clr_cursor", 32'({cur_row, cur_col}), 32'd0);
    chk("clr_ready", {31'b0, cmd_ready}, 32'd1);

    // commands queued behind a clear
    issue(2'b10, 16'h0);
    issue(2'b00, 16'h0741);
    issue(2'b00, 16'h0742);
    wait_idle();
    chk("q_mem0", 32'(mem[12'h000]), 32'h0741);
    chk("q_mem1", 32'(mem[12'h001]), 32'h0742);
    chk("q_mem2", 32'(mem[12'h002]), 32'(BLANK));
    chk("q_cursor", 32'({cur_row, cur_col}), 32'({5'd0, 7'd2}));

    do_scroll("scr");

    // same work with random wait stalls
    stall_en = 1'b1;
    issue(2'b11, 16'h054F);
    w0 = n_wr;
    issue(2'b00, 16'h0742);
    wait_idle();
    chk("st_put_writes", 32'(n_wr - w0), 32'd1);
    chk("st_put_addr", 32'(last_addr), 32'h2CF);
    chk("st_put_data", 32'(last_data), 32'h0742);
    chk("st_put_cursor", 32'({cur_row, cur_col}), 32'({5'd6, 7'd0}));
    do_scroll("st_scr");

    // reset in the middle of a scroll
    preload();
    issue(2'b11, {3'b0, 5'd29, 1'b0, 7'd0});
    issue(2'b01, 16'h0);
    repeat (200) @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_en", {31'b0, dsp_en}, 32'd0);
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_cursor", 32'({cur_row, cur_col}), 32'd0);
    w0 = n_wr + n_rd;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("mr_no_access", 32'(n_wr + n_rd - w0), 32'd0);
    chk("mr_en_after", {31'b0, dsp_en}, 32'd0);
    stall_en = 1'b0;
    repeat (2) @(negedge clk);

    chk("bad_addr", 32'(n_bad), 32'd0);
    chk("ready_vs_busy", 32'(rdy_bad), 32'd0);
    chk("stall_stable", 32'(stall_bad), 32'd0);
    chk("stall_seen", {31'b0, stall_chk > 0}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
